// File: rtl/reg_trace.sv
// rtl/reg_trace.sv - register change tracer: timestamped snapshots into a FWFT circular buffer
module reg_trace #(
    parameter int DW    = 8,
    parameter int NREG  = 3,
    parameter int DEPTH = 16,
    parameter int TSW   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREG*DW-1:0]           regs,
    input  logic                         en,
    input  logic                         mode,
    input  logic                         clr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [TSW-1:0]               out_ts,
    output logic [NREG*DW-1:0]           out_regs,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         overflow,
    output logic [7:0]                   drop_cnt
);
    localparam int RW = NREG * DW;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [TSW-1:0] ts_q, ts_d;
    logic [RW-1:0]  last_cap_q, last_cap_d;
    logic           first_pending_q, first_pending_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           overflow_q, overflow_d;
    logic [7:0]     drop_cnt_q, drop_cnt_d;
    logic [TSW-1:0] ts_mem_q [DEPTH];
    logic [RW-1:0]  regs_mem_q [DEPTH];

    logic capture, pop, full, push, drop, wr_en;

    always_comb begin
        ts_d            = ts_q + TSW'(1);
        last_cap_d      = last_cap_q;
        first_pending_d = first_pending_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        level_d         = level_q;
        overflow_d      = overflow_q;
        drop_cnt_d      = drop_cnt_q;
        wr_en           = 1'b0;

        capture = en && (!mode || first_pending_q || (regs != last_cap_q));
        pop     = (level_q != '0) && out_ready;
        full    = (level_q == FULL_LVL);
        // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;

        if (clr) begin
            wr_ptr_d        = '0;
            rd_ptr_d        = '0;
            level_d         = '0;
            overflow_d      = 1'b0;
            drop_cnt_d      = '0;
            first_pending_d = 1'b1;
        end else begin
            wr_en = push;
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            level_d = level_q + LW'(push) - LW'(pop);
            if (capture) begin
                last_cap_d      = regs;
                first_pending_d = 1'b0;
            end
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q            <= '0;
            last_cap_q      <= '0;
            first_pending_q <= 1'b1;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            overflow_q      <= 1'b0;
            drop_cnt_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ts_mem_q[i]   <= '0;
                regs_mem_q[i] <= '0;
            end
        end else begin
            ts_q            <= ts_d;
            last_cap_q      <= last_cap_d;
            first_pending_q <= first_pending_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            level_q         <= level_d;
            overflow_q      <= overflow_d;
            drop_cnt_q      <= drop_cnt_d;
            if (wr_en) begin
                ts_mem_q[wr_ptr_q]   <= ts_q;
                regs_mem_q[wr_ptr_q] <= regs;
            end
        end
    end

    assign out_valid = (level_q != '0);
    assign out_ts    = ts_mem_q[rd_ptr_q];
    assign out_regs  = regs_mem_q[rd_ptr_q];
    assign level     = level_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_reg_trace.sv
// tb/tb_reg_trace.sv - directed self-checking bench for reg_trace
module tb_reg_trace;
    logic        clk = 1'b0;
    logic        rst, en, mode, clr, out_ready;
    logic [23:0] regs;
    logic        out_valid, overflow;
    logic [15:0] out_ts;
    logic [23:0] out_regs;
    logic [2:0]  level;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    reg_trace #(.DW(8), .NREG(3), .DEPTH(4), .TSW(16)) dut (
        .clk(clk), .rst(rst), .regs(regs), .en(en), .mode(mode), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_ts(out_ts),
        .out_regs(out_regs), .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        mode = 1'b0; regs = '0;
        do_reset();
        chk("rst_level", 32'(level), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_drop", 32'(drop_cnt), 0);

        // Scenario 1: three captures in mode 0
        mode = 1'b0; en = 1'b1; regs = 24'h020100;
        repeat (3) tick();
        en = 1'b0;
        chk("s1_level", 32'(level), 3);
        chk("s1_regs", 32'(out_regs), 32'h020100);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("s1_ts%0d", i), 32'(out_ts), i);
            tick();
        end
        chk("s1_empty", 32'(out_valid), 0);

        // Scenario 2: change detection in mode 1
        do_reset();
        mode = 1'b1; en = 1'b1; regs = 24'h050505;
        repeat (5) tick();
        regs = 24'h050605;
        repeat (2) tick();
        en = 1'b0;
        chk("s2_level", 32'(level), 2);
        chk("s2_ts0", 32'(out_ts), 0);
        chk("s2_regs0", 32'(out_regs), 32'h050505);
        out_ready = 1'b1;
        tick();
        chk("s2_ts1", 32'(out_ts), 5);
        chk("s2_regs1", 32'(out_regs), 32'h050605);
        tick();
        chk("s2_empty", 32'(level), 0);

        // Scenario 3: overflow then drain
        do_reset();
        mode = 1'b0; en = 1'b1; regs = 24'h0a0b0c;
        repeat (6) tick();
        en = 1'b0;
        chk("s3_level", 32'(level), 4);
        chk("s3_ovf", 32'(overflow), 1);
        chk("s3_drop", 32'(drop_cnt), 2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s3_ts%0d", i), 32'(out_ts), i);
            tick();
        end
        chk("s3_empty", 32'(level), 0);

        // Scenario 4: full buffer with simultaneous push and pop; pointers wrap
        do_reset();
        en = 1'b1;
        repeat (4) tick();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("s4_head%0d", i), 32'(out_ts), i);
            tick();
            chk($sformatf("s4_level%0d", i), 32'(level), 4);
        end
        en = 1'b0;
        chk("s4_drop", 32'(drop_cnt), 0);
        chk("s4_ovf", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s4_drain%0d", i), 32'(out_ts), 3 + i);
            tick();
        end

        // Scenario 5: clr flushes and re-arms first capture
        do_reset();
        mode = 1'b0; en = 1'b1; out_ready = 1'b0; regs = 24'h112233;
        repeat (5) tick();
        en = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("s5_pre_level", 32'(level), 3);
        chk("s5_pre_ovf", 32'(overflow), 1);
        clr = 1'b1; en = 1'b1;
        tick();
        clr = 1'b0; en = 1'b0;
        chk("s5_level", 32'(level), 0);
        chk("s5_ovf", 32'(overflow), 0);
        chk("s5_drop", 32'(drop_cnt), 0);
        mode = 1'b1; en = 1'b1;
        tick();
        chk("s5_cap_level", 32'(level), 1);
        chk("s5_cap_ts", 32'(out_ts), 7);
        tick();
        chk("s5_nochange", 32'(level), 1);
        en = 1'b0;

        // Scenario 6: reset mid-operation
        do_reset();
        mode = 1'b0;
        repeat (38) tick();
        en = 1'b1;
        repeat (2) tick();
        en = 1'b0;
        chk("s6_pre_level", 32'(level), 2);
        chk("s6_pre_ts", 32'(out_ts), 38);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("s6_valid", 32'(out_valid), 0);
        chk("s6_level", 32'(level), 0);
        en = 1'b1;
        tick();
        en = 1'b0;
        chk("s6_ts", 32'(out_ts), 0);

        // drop_cnt saturation: 4 stored, 296 dropped
        do_reset();
        mode = 1'b0; en = 1'b1;
        repeat (300) tick();
        en = 1'b0;
        chk("sat_drop", 32'(drop_cnt), 255);
        chk("sat_level", 32'(level), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
